// File: rtl/axil_test_ram.sv
`default_nettype none
// =====================================================================
// Module : axil_test_ram
// AXI4-Lite slave RAM with a tohost exit mailbox and a read pipeline.
// Rev    : 1.0  initial release
// =====================================================================
module axil_test_ram #(
  parameter int                    DATA_WIDTH     = 128,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 18,
  parameter int                    READ_LATENCY   = 1,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h0004_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  // write response channel
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  // exit mailbox
  output logic                      done,
  output logic [31:0]               exit_code
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(STRB_WIDTH);
  localparam int INDEX_WIDTH = MEM_ADDR_WIDTH - OFFSET_BITS;
  localparam int DEPTH       = 2 ** INDEX_WIDTH;
  localparam int LAST        = READ_LATENCY - 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0]   RAM_LIMIT  = (ADDR_WIDTH + 1)'(1) << MEM_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_MBOX = 2'd1,
    TGT_ERR  = 2'd2
  } target_e;

  // Mailbox wins over RAM so TOHOST_ADDR may sit inside the RAM window.
  function automatic target_e decode(input logic [ADDR_WIDTH-1:0] addr);
    if ((addr & ~ALIGN_MASK) == TOHOST_ADDR) return TGT_MBOX;
    if ({1'b0, addr} < RAM_LIMIT)            return TGT_RAM;
    return TGT_ERR;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   done_q, done_d;
  logic [31:0]            exit_code_q, exit_code_d;
  logic [LAST:0]          pipe_valid_q, pipe_valid_d;
  logic [DATA_WIDTH-1:0]  pipe_data_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]  pipe_data_d [READ_LATENCY];
  logic [1:0]             pipe_resp_q [READ_LATENCY];
  logic [1:0]             pipe_resp_d [READ_LATENCY];

  logic                   wr_hs, rd_hs;
  target_e                wr_tgt, rd_tgt;
  logic [INDEX_WIDTH-1:0] wr_idx, rd_idx;
  logic                   unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  assign wr_tgt = decode(s_axil_awaddr);
  assign rd_tgt = decode(s_axil_araddr);
  assign wr_idx = s_axil_awaddr[MEM_ADDR_WIDTH-1:OFFSET_BITS];
  assign rd_idx = s_axil_araddr[MEM_ADDR_WIDTH-1:OFFSET_BITS];

  // Address and data are accepted together, so no write data is ever buffered.
  assign s_axil_awready = rst_n && s_axil_awvalid && s_axil_wvalid && !bvalid_q;
  assign s_axil_wready  = s_axil_awready;
  assign wr_hs          = s_axil_awready;

  // Any valid stage, including the output stage, blocks a new read.
  assign s_axil_arready = rst_n && !(|pipe_valid_q);
  assign rd_hs          = s_axil_arvalid && s_axil_arready;

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = pipe_valid_q[LAST];
  assign s_axil_rdata  = pipe_data_q[LAST];
  assign s_axil_rresp  = pipe_resp_q[LAST];
  assign done          = done_q;
  assign exit_code     = exit_code_q;

  always_comb begin
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    done_d      = done_q;
    exit_code_d = exit_code_q;
    if (bvalid_q && s_axil_bready) begin
      bvalid_d = 1'b0;
    end
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = (wr_tgt == TGT_ERR) ? RESP_SLVERR : RESP_OKAY;
      if (wr_tgt == TGT_MBOX) begin
        done_d      = 1'b1;
        exit_code_d = s_axil_wdata[31:0];
      end
    end
  end

  // Only one read is ever in flight, so a token moves forward without collisions
  // and parks in the last stage until RREADY.
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    pipe_data_d  = pipe_data_q;
    pipe_resp_d  = pipe_resp_q;
    if (pipe_valid_q[LAST] && s_axil_rready) begin
      pipe_valid_d[LAST] = 1'b0;
    end
    for (int k = LAST; k > 0; k--) begin
      if (pipe_valid_q[k-1]) begin
        pipe_valid_d[k]   = 1'b1;
        pipe_data_d[k]    = pipe_data_q[k-1];
        pipe_resp_d[k]    = pipe_resp_q[k-1];
        pipe_valid_d[k-1] = 1'b0;
      end
    end
    if (rd_hs) begin
      pipe_valid_d[0] = 1'b1;
      unique case (rd_tgt)
        TGT_RAM: begin
          pipe_data_d[0] = mem[rd_idx];
          pipe_resp_d[0] = RESP_OKAY;
        end
        TGT_MBOX: begin
          pipe_data_d[0] = DATA_WIDTH'(exit_code_q);
          pipe_resp_d[0] = RESP_OKAY;
        end
        default: begin
          pipe_data_d[0] = '0;
          pipe_resp_d[0] = RESP_SLVERR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      done_q       <= 1'b0;
      exit_code_q  <= '0;
      pipe_valid_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data_q[k] <= '0;
        pipe_resp_q[k] <= RESP_OKAY;
      end
    end else begin
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      done_q       <= done_d;
      exit_code_q  <= exit_code_d;
      pipe_valid_q <= pipe_valid_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data_q[k] <= pipe_data_d[k];
        pipe_resp_q[k] <= pipe_resp_d[k];
      end
    end
  end

  // Storage is deliberately not reset so preloaded images survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_hs && (wr_tgt == TGT_RAM)) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axil_wstrb[i]) begin
          mem[wr_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_test_ram.sv
`default_nettype none
// =====================================================================
// Module : tb_axil_test_ram
// Randomized self-checking bench for axil_test_ram against a byte model.
// Rev    : 1.0  initial release
// =====================================================================
module tb_axil_test_ram;

  localparam int          DW        = 128;
  localparam int          AW        = 32;
  localparam int          MAW       = 18;
  localparam int          RL        = 3;
  localparam logic [31:0] TOHOST    = 32'h0004_0000;
  localparam logic [31:0] RAM_BYTES = 32'h1 << MAW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  awaddr = '0;
  logic [2:0]     awprot = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b0;
  logic [AW-1:0]  araddr = '0;
  logic [2:0]     arprot = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b0;
  logic           done;
  logic [31:0]    exit_code;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: byte-addressed storage plus mailbox state.
  logic [7:0]  model_mem [int unsigned];
  logic [31:0] m_exit = '0;
  logic        m_done = 1'b0;

  axil_test_ram #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MEM_ADDR_WIDTH (MAW),
    .READ_LATENCY   (RL),
    .TOHOST_ADDR    (TOHOST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .done           (done),
    .exit_code      (exit_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [127:0] d,
                                             input logic [15:0] s);
    logic [31:0] base;
    base = a & ~32'hF;
    if (base == TOHOST) begin
      m_exit = d[31:0];
      m_done = 1'b1;
      return 2'b00;
    end
    if (a < RAM_BYTES) begin
      for (int i = 0; i < 16; i++)
        if (s[i]) model_mem[base + 32'(i)] = d[8*i +: 8];
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic logic [1:0] exp_read(input logic [31:0] a, output logic [127:0] d);
    logic [31:0] base;
    base = a & ~32'hF;
    d = '0;
    if (base == TOHOST) begin
      d[31:0] = m_exit;
      return 2'b00;
    end
    if (a < RAM_BYTES) begin
      for (int i = 0; i < 16; i++)
        d[8*i +: 8] = model_mem.exists(base + 32'(i)) ? model_mem[base + 32'(i)] : 8'h00;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                           output logic [1:0] resp, output int lat, output bit ok);
    int n;
    @(negedge clk);
    awaddr = a; awprot = 3'($urandom_range(7)); wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    ok = awready;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    #1;
    while (!bvalid && lat < 50) begin @(negedge clk); #1; lat++; end
    resp = bresp;
    ok = ok && bvalid;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [127:0] d, output logic [1:0] resp,
                          output int lat, output bit ok);
    int n;
    @(negedge clk);
    araddr = a; arprot = 3'($urandom_range(7)); arvalid = 1'b1; rready = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    ok = arready;
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    #1;
    while (!rvalid && lat < 50) begin @(negedge clk); #1; lat++; end
    d = rdata; resp = rresp;
    ok = ok && rvalid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; awaddr = 32'h0008_0000; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      $display("FAIL reset_handshake: aw/w/ar/b/r = %b, expected 00000",
               {awready, wready, arready, bvalid, rvalid});
    end else n_pass++;
    n_checks++;
    if ({bresp, rresp} !== 4'b0 || rdata !== '0) begin
      $display("FAIL reset_resp: bresp=%b rresp=%b rdata=%h, expected zeros", bresp, rresp, rdata);
    end else n_pass++;
    n_checks++;
    if (done !== 1'b0 || exit_code !== 32'h0) begin
      $display("FAIL reset_mailbox: done=%b exit_code=%h, expected 0/0", done, exit_code);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    #1;
    n_checks++;
    if (arready !== 1'b1) begin
      $display("FAIL reset_first_edge: arready=%b, expected 1", arready);
    end else n_pass++;
  endtask

  task automatic test_preload_read();
    logic [127:0] got, v;
    logic [1:0] resp;
    int lat, bad;
    bit ok;
    bad = 0;
    for (int w = 0; w < 64; w++) begin
      v = rand128();
      void'(model_write(32'(w) << 4, v, 16'hFFFF));
      axi_write(32'(w) << 4, v, 16'hFFFF, resp, lat, ok);
      if (!ok || resp !== 2'b00) bad++;
    end
    v = rand128();
    void'(model_write(32'h0003_FFF0, v, 16'hFFFF));
    axi_write(32'h0003_FFF0, v, 16'hFFFF, resp, lat, ok);
    if (!ok || resp !== 2'b00) bad++;
    v = 128'h0123456789ABCDEF0123456789ABCDEF;
    void'(model_write(32'h1000, v, 16'hFFFF));
    axi_write(32'h1000, v, 16'hFFFF, resp, lat, ok);
    if (!ok || resp !== 2'b00) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL preload_writes: %0d bad responses, expected 0", bad);
    else n_pass++;

    axi_read(32'h1000, got, resp, lat, ok);
    n_checks++;
    if (!ok || lat != RL) $display("FAIL read_latency: ok=%0d lat=%0d, expected %0d", ok, lat, RL);
    else n_pass++;
    n_checks++;
    if (got !== 128'h0123456789ABCDEF0123456789ABCDEF || resp !== 2'b00)
      $display("FAIL preload_read: rdata=%h rresp=%b, expected 0123456789abcdef0123456789abcdef/00",
               got, resp);
    else n_pass++;
  endtask

  task automatic test_strobe_write();
    logic [127:0] got, exp, old;
    logic [1:0] resp;
    int lat;
    bit ok;
    void'(exp_read(32'h20, old));
    void'(model_write(32'h20, {16{8'hAA}}, 16'h000F));
    axi_write(32'h20, {16{8'hAA}}, 16'h000F, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00 || lat != 1)
      $display("FAIL strobe_bresp: ok=%0d bresp=%b lat=%0d, expected 1/00/1", ok, resp, lat);
    else n_pass++;
    void'(exp_read(32'h20, exp));
    axi_read(32'h20, got, resp, lat, ok);
    n_checks++;
    if (!ok || got !== exp || got[31:0] !== 32'hAAAA_AAAA || got[127:32] !== old[127:32])
      $display("FAIL strobe_read: rdata=%h, expected %h", got, exp);
    else n_pass++;
  endtask

  task automatic test_mailbox();
    logic [127:0] got;
    logic [1:0] resp;
    int lat;
    bit ok;
    void'(model_write(TOHOST, 128'h1, 16'hFFFF));
    axi_write(TOHOST, 128'h1, 16'hFFFF, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00 || done !== 1'b1 || exit_code !== 32'h1)
      $display("FAIL mbox_first: bresp=%b done=%b exit_code=%h, expected 00/1/00000001",
               resp, done, exit_code);
    else n_pass++;
    void'(model_write(TOHOST, 128'h5, 16'h0000));
    axi_write(TOHOST, 128'h5, 16'h0000, resp, lat, ok);
    n_checks++;
    if (!ok || done !== 1'b1 || exit_code !== 32'h5)
      $display("FAIL mbox_second: done=%b exit_code=%h, expected 1/00000005", done, exit_code);
    else n_pass++;
    axi_read(TOHOST, got, resp, lat, ok);
    n_checks++;
    if (!ok || got !== 128'h5 || resp !== 2'b00)
      $display("FAIL mbox_read: rdata=%h rresp=%b, expected 5/00", got, resp);
    else n_pass++;
  endtask

  task automatic test_range();
    logic [127:0] got, exp, v;
    logic [1:0] resp;
    int lat;
    bit ok;
    v = rand128();
    void'(model_write(32'h0003_FFF0, v, 16'hFFFF));
    axi_write(32'h0003_FFF0, v, 16'hFFFF, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00) $display("FAIL top_write: bresp=%b, expected 00", resp);
    else n_pass++;
    axi_read(32'h0003_FFF0, got, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b00 || got !== v)
      $display("FAIL top_read: rdata=%h rresp=%b, expected %h/00", got, resp, v);
    else n_pass++;
    axi_write(32'h0008_0000, rand128(), 16'hFFFF, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b10) $display("FAIL err_write: bresp=%b, expected 10", resp);
    else n_pass++;
    axi_read(32'h0008_0000, got, resp, lat, ok);
    n_checks++;
    if (!ok || resp !== 2'b10 || got !== '0)
      $display("FAIL err_read: rdata=%h rresp=%b, expected 0/10", got, resp);
    else n_pass++;
    void'(exp_read(32'h0, exp));
    axi_read(32'h0, got, resp, lat, ok);
    n_checks++;
    if (!ok || got !== exp) $display("FAIL err_no_alias: word0=%h, expected %h", got, exp);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [127:0] wd, wd2, rexp, got;
    logic [1:0] resp;
    int n, lat;
    bit ok;
    wd = rand128(); wd2 = rand128();
    void'(exp_read(32'h60, rexp));
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h50; wdata = wd; wstrb = 16'hFFFF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h60; arvalid = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1)
      $display("FAIL bp_accept: awready=%b arready=%b, expected 1/1", awready, arready);
    else n_pass++;
    void'(model_write(32'h50, wd, 16'hFFFF));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    #1;
    while (!rvalid && n < 10) begin @(negedge clk); #1; n++; end
    awaddr = 32'h70; wdata = wd2; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== rexp)
        $display("FAIL bp_hold_resp: cycle %0d bvalid=%b bresp=%b rvalid=%b rdata=%h, expected 1/00/1/%h",
                 c, bvalid, bresp, rvalid, rdata, rexp);
      else n_pass++;
      n_checks++;
      if (awready !== 1'b0 || arready !== 1'b0)
        $display("FAIL bp_hold_ready: cycle %0d awready=%b arready=%b, expected 0/0", c, awready, arready);
      else n_pass++;
    end
    bready = 1'b1; rready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || arready !== 1'b1)
      $display("FAIL bp_release: bvalid=%b rvalid=%b awready=%b arready=%b, expected 0/0/1/1",
               bvalid, rvalid, awready, arready);
    else n_pass++;
    void'(model_write(32'h70, wd2, 16'hFFFF));
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    axi_read(32'h70, got, resp, lat, ok);
    n_checks++;
    if (!ok || got !== wd2) $display("FAIL bp_probe_write: rdata=%h, expected %h", got, wd2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [127:0] d, got, exp;
    logic [15:0] s;
    logic [1:0] resp, eresp;
    int lat, r;
    bit ok;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(9);
      if (r == 0)      a = 32'h0008_0000 + 32'($urandom_range(4095));
      else if (r == 1) a = TOHOST + 32'($urandom_range(15));
      else             a = (32'($urandom_range(63)) << 4) | 32'($urandom_range(15));
      if ($urandom_range(1) == 0) begin
        d = rand128(); s = 16'($urandom());
        eresp = model_write(a, d, s);
        axi_write(a, d, s, resp, lat, ok);
        n_checks++;
        if (!ok || resp !== eresp || lat != 1)
          $display("FAIL rand_write: addr=%h bresp=%b lat=%0d, expected %b/1", a, resp, lat, eresp);
        else n_pass++;
        n_checks++;
        if (done !== m_done || exit_code !== m_exit)
          $display("FAIL rand_mbox: done=%b exit_code=%h, expected %b/%h", done, exit_code, m_done, m_exit);
        else n_pass++;
      end else begin
        eresp = exp_read(a, exp);
        axi_read(a, got, resp, lat, ok);
        n_checks++;
        if (!ok || resp !== eresp || got !== exp || lat != RL)
          $display("FAIL rand_read: addr=%h rdata=%h rresp=%b lat=%0d, expected %h/%b/%0d",
                   a, got, resp, lat, exp, eresp, RL);
        else n_pass++;
      end
    end
  endtask

  task automatic test_same_cycle_and_reset();
    logic [127:0] got;
    logic [1:0] resp;
    int n, lat;
    bit ok, seen;
    void'(model_write(32'h40, {16{8'h11}}, 16'hFFFF));
    axi_write(32'h40, {16{8'h11}}, 16'hFFFF, resp, lat, ok);
    @(negedge clk);
    araddr = 32'h40; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'h40; wdata = {16{8'h22}}; wstrb = 16'hFFFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b1 || arready !== 1'b1)
      $display("FAIL same_cycle_accept: awready=%b arready=%b, expected 1/1", awready, arready);
    else n_pass++;
    void'(model_write(32'h40, {16{8'h22}}, 16'hFFFF));
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    #1;
    while (!rvalid && n < 10) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== {16{8'h11}})
      $display("FAIL same_cycle_old: rvalid=%b rdata=%h, expected 1/%h", rvalid, rdata, {16{8'h11}});
    else n_pass++;
    @(posedge clk); #1;
    axi_read(32'h40, got, resp, lat, ok);
    n_checks++;
    if (!ok || got !== {16{8'h22}}) $display("FAIL same_cycle_new: rdata=%h, expected %h", got, {16{8'h22}});
    else n_pass++;

    @(negedge clk);
    araddr = 32'h1000; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    rst_n = 1'b0;
    m_done = 1'b0; m_exit = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (rvalid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL reset_abort: rvalid=1 seen after reset, expected none");
    else n_pass++;
    n_checks++;
    if (done !== m_done || exit_code !== m_exit)
      $display("FAIL reset_done: done=%b exit_code=%h, expected 0/0", done, exit_code);
    else n_pass++;
    axi_read(32'h40, got, resp, lat, ok);
    n_checks++;
    if (!ok || got !== {16{8'h22}}) $display("FAIL mem_survives_reset: rdata=%h, expected %h", got, {16{8'h22}});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_strobe_write();
    test_mailbox();
    test_range();
    test_backpressure();
    test_random();
    test_same_cycle_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_test_ram.md
AXIL_TEST_RAM -- requirements
Module: axil_test_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: AXI-Lite data width; legal values 32, 64, 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI-Lite address width.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 18: byte-address span of the RAM, giving 2^MEM_ADDR_WIDTH bytes.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal 1..4: cycles from AR handshake to RVALID.
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h0004_0000: byte address of the exit mailbox, word aligned.
REQ-006 Port: clk, input, 1, single clock; all logic is rising-edge.
REQ-007 Port: rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-008 Ports: s_axil_aw{addr,prot,valid,ready}, s_axil_w{data,strb,valid,ready}, s_axil_b{resp,valid,ready}, s_axil_ar{addr,prot,valid,ready}, s_axil_r{data,resp,valid,ready}; standard AXI4-Lite slave; widths ADDR_WIDTH, 3, DATA_WIDTH, DATA_WIDTH/8, 2.
REQ-009 Port: done, output, 1, sticky flag set by a mailbox write.
REQ-010 Port: exit_code, output, 32, value written to the mailbox.
REQ-011 The storage array SHALL be named mem, one DATA_WIDTH word per entry, so a bench can preload it with $readmemh on <inst>.mem.

Function
REQ-012 Word index SHALL be addr[MEM_ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; the low byte-offset bits are ignored.
REQ-013 Decode SHALL classify each address as one of three targets, in this priority:
 - MBOX: addr word-aligned equals TOHOST_ADDR.
 - RAM: addr < 2^MEM_ADDR_WIDTH.
 - ERR: any other address.
REQ-014 Write accept rules:
 - AWREADY and WREADY SHALL assert together, in the same cycle, only when AWVALID && WVALID && no B response is pending.
 - No write data SHALL be buffered separately from its address.
REQ-015 Write effect, on the accept edge:
 - RAM: each byte lane i with WSTRB[i]=1 is written.
 - MBOX: exit_code <= WDATA[31:0] and done <= 1, regardless of WSTRB.
 - ERR: no state changes.
REQ-016 BVALID SHALL rise the cycle after write accept and hold until BREADY.
 - BRESP = OKAY (2'b00) for RAM and MBOX.
 - BRESP = SLVERR (2'b10) for ERR.
REQ-017 Read accept rules:
 - Single outstanding read.
 - ARREADY = 1 only when no read is in flight and RVALID is low.
REQ-018 Read data SHALL be sampled at the AR handshake edge and carried through a READ_LATENCY-stage pipeline.
 - RVALID rises exactly READ_LATENCY cycles after the handshake and holds, with RDATA/RRESP stable, until RREADY.
REQ-019 Read response per target:
 - RAM: mem word, RRESP OKAY.
 - MBOX: {zero, exit_code}, RRESP OKAY.
 - ERR: all-zero RDATA, RRESP SLVERR.
REQ-020 Read/write ordering:
 - Read and write channels are independent; both may handshake in the same cycle.
 - If both hit the same RAM word in that cycle, the read SHALL return pre-write data.
REQ-021 Once set, done SHALL stay 1 until reset; a later mailbox write updates exit_code only.
REQ-022 AxPROT SHALL be ignored.

Reset
REQ-023 While rst_n=0, all of the following SHALL be 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, done, exit_code, and the read pipeline valid bits.
REQ-024 Reset asserted mid-transaction SHALL abort it:
 - A pending B or R response is dropped, not delivered after deassert.
 - An in-flight pipeline read is discarded.
REQ-025 mem contents SHALL NOT be reset; preloaded and written data survive rst_n.
REQ-026 The first handshake SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-027 Preload mem[0x100]=128'h0123..CDEF; AR addr 0x1000, RREADY=1, READ_LATENCY=3 -> RVALID exactly 3 cycles after the handshake, RDATA=preload, RRESP=0.
REQ-028 Write addr 0x20, WSTRB=16'h000F, WDATA=all 0xAA, then read 0x20 -> bytes 0-3 read 0xAA, bytes 4-15 unchanged, BRESP=0.
REQ-029 Write 32'h0000_0001 to TOHOST_ADDR -> done=1 and exit_code=1 next cycle; second write 5 -> exit_code=5, done stays 1; read of the mailbox returns 5.
REQ-030 Read and write of 0x3_FFF0 (in range) and 0x8_0000 (ERR):
 - 0x3_FFF0: OKAY.
 - 0x8_0000: SLVERR, RDATA=0, mem unchanged.
REQ-031 Hold BREADY=0 and RREADY=0 for 5 cycles:
 - BVALID/RVALID and their data stay stable throughout.
 - AWREADY and ARREADY stay 0 until the responses complete.
REQ-032 Same-cycle AR+AW/W to 0x40 (old 0x11, new 0x22) -> R returns 0x11; a following read returns 0x22. Then assert rst_n=0 with a read in flight -> no RVALID after release, done=0.
